quad_decoder_x: RTL

//  Parametrised quadrature encoder interface: synchronises and deglitches A/B/Z pins,

---
 rtl/quad_decoder_x.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/quad_decoder_x.sv
`default_nettype none
// ============================================================================
//  Module   : quad_decoder_x
//  Purpose  : Quadrature encoder interface for one motor axis. Synchronises
//             and deglitches the A/B/Z pins, tracks the Gray phase in an FSM,
//             counts x1/x2/x4 steps into a wrapping position register, zeroes
//             the position on an index pulse and flags illegal double jumps.
//  Ports    :
//    clk         in   1      clock
//    reset_n     in   1      asynchronous active-low reset
//    a, b        in   1      asynchronous quadrature inputs
//    z           in   1      asynchronous index input
//    mode        in   2      00=x4, 01=x2, 10=x1, 11=x4
//    index_en    in   1      allow index pulse to zero the count
//    cnt_clr     in   1      synchronous clear of count and index_seen
//    err_clr     in   1      synchronous clear of err, releases ERR state
//    count       out  CNT_W  position, two's complement, wraps
//    dir         out  1      direction of last counted step (1=fwd)
//    step        out  1      one-cycle pulse per counted step
//    err         out  1      sticky illegal-transition flag
//    index_seen  out  1      sticky: index zeroing has occurred
//  Revision : 1.0 - initial release
// ============================================================================
module quad_decoder_x #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a,
    input  logic             b,
    input  logic             z,
    input  logic [1:0]       mode,
    input  logic             index_en,
    input  logic             cnt_clr,
    input  logic             err_clr,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic             index_seen
);

    localparam int RUN_W    = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);
    localparam int SETTLE   = SYNC_STAGES + FILT_LEN;
    localparam int SETTLE_W = $clog2(SETTLE + 1);

    localparam logic [RUN_W-1:0]    RUN_LAST    = RUN_W'(FILT_LEN - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE);

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_S00  = 3'd1,
        ST_S01  = 3'd2,
        ST_S11  = 3'd3,
        ST_S10  = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Pin conditioning: bit 2 = a, bit 1 = b, bit 0 = z
    // ------------------------------------------------------------------------
    logic [2:0] raw;
    logic [2:0] filt;

    assign raw = {a, b, z};

    for (genvar gi = 0; gi < 3; gi++) begin : g_pin
        logic [SYNC_STAGES-1:0] sync_sr;
        logic [RUN_W-1:0]       run;
        logic                   filt_bit;

        // The run counter only advances while the synchronised pin disagrees
        // with the filtered value; any agreement restarts it, so a level must
        // persist FILT_LEN consecutive cycles before it is accepted.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_sr  <= '0;
                run      <= '0;
                filt_bit <= 1'b0;
            end else begin
                sync_sr <= {sync_sr[SYNC_STAGES-2:0], raw[gi]};
                if (sync_sr[SYNC_STAGES-1] == filt_bit) begin
                    run <= '0;
                end else if (run == RUN_LAST) begin
                    filt_bit <= sync_sr[SYNC_STAGES-1];
                    run      <= '0;
                end else begin
                    run <= run + RUN_W'(1);
                end
            end
        end

        assign filt[gi] = filt_bit;
    end

    // ------------------------------------------------------------------------
    // Phase helpers
    // ------------------------------------------------------------------------
    function automatic state_t phase_state(input logic [1:0] p);
        case (p)
            2'b00:   return ST_S00;
            2'b01:   return ST_S01;
            2'b11:   return ST_S11;
            default: return ST_S10;
        endcase
    endfunction

    // Ring position of a phase state: S00=0, S01=1, S11=2, S10=3.
    function automatic logic [1:0] state_pos(input state_t s);
        case (s)
            ST_S01:  return 2'd1;
            ST_S11:  return 2'd2;
            ST_S10:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // lo is the ring position the transition starts from when viewed in the
    // forward direction. x2 counts the 1<->2 and 3<->0 edges (odd lo), x1
    // counts only the 3<->0 edge.
    function automatic logic is_counted(input logic [1:0] lo, input logic [1:0] md);
        case (md)
            2'b01:   return lo[0];
            2'b10:   return (lo == 2'd3);
            default: return 1'b1;
        endcase
    endfunction

    logic [1:0] ph;
    logic [1:0] cur_pos;
    logic [1:0] new_pos;
    logic [1:0] delta;

    assign ph      = filt[2:1];
    // Gray-to-binary turns the filtered phase into its ring position.
    assign new_pos = {ph[1], ph[1] ^ ph[0]};

    // ------------------------------------------------------------------------
    // Phase FSM
    // ------------------------------------------------------------------------
    state_t              state;
    state_t              state_nxt;
    logic [SETTLE_W-1:0] settle;
    logic [SETTLE_W-1:0] settle_nxt;
    logic                err_set;
    logic                step_fwd;
    logic                step_rev;

    assign cur_pos = state_pos(state);
    assign delta   = new_pos - cur_pos;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_INIT;
            settle <= '0;
        end else begin
            state  <= state_nxt;
            settle <= settle_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle;
        err_set    = 1'b0;
        step_fwd   = 1'b0;
        step_rev   = 1'b0;
        case (state)
            ST_INIT: begin
                // Let the synchronisers and filters fill before trusting ph.
                if (settle == SETTLE_LAST) begin
                    state_nxt = phase_state(ph);
                end else begin
                    settle_nxt = settle + SETTLE_W'(1);
                end
            end
            ST_ERR: begin
                if (err_clr) begin
                    state_nxt = phase_state(ph);
                end
            end
            default: begin
                case (delta)
                    2'd1: begin
                        state_nxt = phase_state(ph);
                        step_fwd  = is_counted(cur_pos, mode);
                    end
                    2'd3: begin
                        state_nxt = phase_state(ph);
                        step_rev  = is_counted(new_pos, mode);
                    end
                    2'd2: begin
                        state_nxt = ST_ERR;
                        err_set   = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Position, index and status registers
    // ------------------------------------------------------------------------
    logic z_prev;
    logic index_hit;

    assign index_hit = index_en & filt[0] & ~z_prev & (state == ST_S00);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            dir        <= 1'b0;
            step       <= 1'b0;
            err        <= 1'b0;
            index_seen <= 1'b0;
            z_prev     <= 1'b0;
        end else begin
            z_prev <= filt[0];

            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            step <= 1'b0;
            if (cnt_clr) begin
                count      <= '0;
                index_seen <= 1'b0;
            end else if (index_hit) begin
                count      <= '0;
                index_seen <= 1'b1;
            end else if (step_fwd) begin
                count <= count + CNT_W'(1);
                dir   <= 1'b1;
                step  <= 1'b1;
            end else if (step_rev) begin
                count <= count - CNT_W'(1);
                dir   <= 1'b0;
                step  <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
